hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters: CW, 32, width of performance counters; MAX_FREEZE, 16, consecutive freeze cycles before timeout.
REQ-002 Ports: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Ports: reset  in  1  synchronous, active-high.
REQ-004 Ports: ra1_D, ra2_D  in  5 each  source register addresses of the instruction in decode.
REQ-005 Ports: wa3_E  in  5  destination register of the instruction in execute.
REQ-006 Ports: memRead_E, regWrite_E  in  1 each  execute-stage load and write-back flags.
REQ-007 Ports: pcSrc_M  in  1  branch taken, resolved in memory stage.
REQ-008 Ports: dmem_busy_M  in  1  data memory not ready; whole pipeline must hold.
REQ-009 Ports: stall_F, stall_D  out  1 each  hold PC and IF/ID register.
REQ-010 Ports: flush_D, flush_E, flush_M  out  1 each  clear IF/ID, ID/EX, EX/MEM to bubble.
REQ-011 Ports: freeze  out  1  hold every pipeline register.
REQ-012 Ports: state  out  2  FSM state code.
REQ-013 Ports: stall_count, flush_count  out  CW each  performance counters.
REQ-014 Ports: timeout  out  1  sticky freeze-timeout flag.

Function
REQ-015 lu_hazard = memRead_E & regWrite_E & (wa3_E != 31) & (wa3_E == ra1_D | wa3_E == ra2_D); register 31 (XZR) never hazards.
REQ-016 Priority, highest first: reset, dmem_busy_M, pcSrc_M, lu_hazard.
REQ-017 All hazard outputs combinational from current inputs, same-cycle effect (zero latency).
REQ-018 freeze = dmem_busy_M; while 1, all flush_* = 0 and stall_F = stall_D = 1.
REQ-019 Not frozen, pcSrc_M = 1: flush_D = flush_E = flush_M = 1, stall_F = stall_D = 0; any simultaneous lu_hazard ignored.
REQ-020 Not frozen, pcSrc_M = 0, lu_hazard = 1: stall_F = stall_D = 1, flush_E = 1, flush_D = flush_M = 0.
REQ-021 Otherwise all stall/flush/freeze outputs 0.
REQ-022 FSM states: RUN = 0, LU = 1, BR = 2, FRZ = 3; next state chosen by REQ-016 priority: dmem_busy_M -> FRZ, pcSrc_M -> BR, lu_hazard -> LU, else RUN.
REQ-023 state output reports the registered state, i.e. the condition acted on in the previous cycle.
REQ-024 freeze_run counter: increments each cycle dmem_busy_M = 1, clears to 0 on any cycle with dmem_busy_M = 0; saturates at MAX_FREEZE.
REQ-025 timeout sets when freeze_run reaches MAX_FREEZE while dmem_busy_M = 1; remains 1 until reset.
REQ-026 stall_count increments by 1 on each cycle with stall_D = 1 and freeze = 0; saturates at 2^CW-1, no wrap.
REQ-027 flush_count increments by 1 on each cycle with flush_D = 1; saturates at 2^CW-1.
REQ-028 Back-to-back load-use hazards in consecutive cycles each stall exactly one cycle; counter increments each cycle.

Reset
REQ-029 On reset = 1 at a rising edge: state = RUN, stall_count = 0, flush_count = 0, freeze_run = 0, timeout = 0.
REQ-030 Combinational hazard outputs are not masked by reset; pipeline registers handle their own reset.
REQ-031 Reset asserted mid-freeze or mid-stall returns to RUN next cycle, discarding counts.

Structure
REQ-032 State encoding enum and XZR constant (31) reside in the shared processor package.
REQ-033 One sub-module, sat_counter (parameterised width, inc, clear, saturating), instantiated for stall_count, flush_count and freeze_run.
REQ-034 hazard_ctrl is instantiated at processor top alongside decode, consuming decode's ra1/ra2 outputs.

Verification
REQ-035 ra1_D=3, wa3_E=3, memRead_E=1, regWrite_E=1 -> stall_F=stall_D=flush_E=1 for one cycle, stall_count=1, state=LU next cycle.
REQ-036 ra2_D=31, wa3_E=31, load in EX -> no stall, stall_count unchanged.
REQ-037 pcSrc_M=1 with concurrent lu_hazard -> flush_D=flush_E=flush_M=1, stall_D=0, flush_count=1, state=BR.
REQ-038 dmem_busy_M=1 for 16 cycles with pcSrc_M=1 -> freeze=1, no flushes, timeout=1 after 16th cycle, stays 1 after busy drops.
REQ-039 Force stall_count to 2^CW-1 (CW=4 build) plus one more hazard -> count holds 15.
REQ-040 reset pulse during freeze -> state=RUN, counters=0, timeout=0 on next cycle.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared processor definitions used by the hazard controller.
// State codes, the XZR register number and the hazard detect helper.
package hazard_ctrl_pkg;

    localparam logic [4:0] XZR = 5'd31;

    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_LU  = 2'd1;
    localparam logic [1:0] ST_BR  = 2'd2;
    localparam logic [1:0] ST_FRZ = 2'd3;

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_LU  = 2'd1,
        S_BR  = 2'd2,
        S_FRZ = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic freeze;
    } hz_ctrl_t;

    // A load in EX whose destination feeds the instruction in decode.
    // XZR reads as zero, so it can never carry a dependency.
    function automatic logic lu_detect(
        input logic [4:0] ra1,
        input logic [4:0] ra2,
        input logic [4:0] wa3,
        input logic       mem_read,
        input logic       reg_write
    );
        lu_detect = mem_read & reg_write & (wa3 != XZR) &
                    ((wa3 == ra1) | (wa3 == ra2));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat.sv
// Saturating up-counter with synchronous reset and clear.
// Holds at MAX instead of wrapping.
module sat_counter #(
    parameter int           W   = 32,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stop at MAX, zero on reset or clear.
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (inc && (count < MAX))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory freeze.
// Control outputs are combinational; state and counters are registered.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CW         = 32,
    parameter int MAX_FREEZE = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    ra1_D,
    input  logic [4:0]    ra2_D,
    input  logic [4:0]    wa3_E,
    input  logic          memRead_E,
    input  logic          regWrite_E,
    input  logic          pcSrc_M,
    input  logic          dmem_busy_M,
    output logic          stall_F,
    output logic          stall_D,
    output logic          flush_D,
    output logic          flush_E,
    output logic          flush_M,
    output logic          freeze,
    output logic [1:0]    state,
    output logic [CW-1:0] stall_count,
    output logic [CW-1:0] flush_count,
    output logic          timeout
);

    localparam int FW = $clog2(MAX_FREEZE + 1);
    localparam logic [FW-1:0] RUN_MAX  = FW'(MAX_FREEZE);
    localparam logic [FW-1:0] RUN_LAST = FW'(MAX_FREEZE - 1);

    logic          lu_hazard;
    hz_ctrl_t      ctl;
    logic [1:0]    state_nxt;
    logic [FW-1:0] freeze_run;

    assign lu_hazard = lu_detect(ra1_D, ra2_D, wa3_E,
                                 memRead_E, regWrite_E);

    // Hazard resolution in priority order: freeze, branch, load-use.
    always_comb begin
        ctl = '0;
        if (dmem_busy_M) begin
            ctl.freeze  = 1'b1;
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
        end else if (pcSrc_M) begin
            ctl.flush_d = 1'b1;
            ctl.flush_e = 1'b1;
            ctl.flush_m = 1'b1;
        end else if (lu_hazard) begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.flush_e = 1'b1;
        end
    end

    assign stall_F = ctl.stall_f;
    assign stall_D = ctl.stall_d;
    assign flush_D = ctl.flush_d;
    assign flush_E = ctl.flush_e;
    assign flush_M = ctl.flush_m;
    assign freeze  = ctl.freeze;

    // Next state records which condition is being acted on this cycle.
    always_comb begin
        state_nxt = ST_RUN;
        if (dmem_busy_M)
            state_nxt = ST_FRZ;
        else if (pcSrc_M)
            state_nxt = ST_BR;
        else if (lu_hazard)
            state_nxt = ST_LU;
    end

    // State register, back to RUN on reset.
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    sat_counter #(
        .W   (CW),
        .MAX ({CW{1'b1}})
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (ctl.stall_d & ~ctl.freeze),
        .count (stall_count)
    );

    sat_counter #(
        .W   (CW),
        .MAX ({CW{1'b1}})
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (ctl.flush_d),
        .count (flush_count)
    );

    sat_counter #(
        .W   (FW),
        .MAX (RUN_MAX)
    ) u_freeze_run (
        .clk   (clk),
        .reset (reset),
        .clear (~dmem_busy_M),
        .inc   (dmem_busy_M),
        .count (freeze_run)
    );

    // Sticky flag: set on the busy cycle that brings the run to MAX_FREEZE.
    always_ff @(posedge clk) begin
        if (reset)
            timeout <= 1'b0;
        else if (dmem_busy_M && (freeze_run >= RUN_LAST))
            timeout <= 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: reference model plus directed vectors.
// Built with CW=4 so counter saturation is reachable quickly.
module tb_hazard_ctrl;

    localparam int CW   = 4;
    localparam int MAXF = 16;
    localparam int SMAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    ra1_D, ra2_D, wa3_E;
    logic          memRead_E, regWrite_E, pcSrc_M, dmem_busy_M;
    logic          stall_F, stall_D, flush_D, flush_E, flush_M, freeze;
    logic [1:0]    state;
    logic [CW-1:0] stall_count, flush_count;
    logic          timeout;

    int n_pass  = 0;
    int n_total = 0;

    int m_state = 0;
    int m_sc    = 0;
    int m_fc    = 0;
    int m_run   = 0;
    int m_to    = 0;
    bit started = 0;

    hazard_ctrl #(.CW(CW), .MAX_FREEZE(MAXF)) dut (
        .clk         (clk),
        .reset       (reset),
        .ra1_D       (ra1_D),
        .ra2_D       (ra2_D),
        .wa3_E       (wa3_E),
        .memRead_E   (memRead_E),
        .regWrite_E  (regWrite_E),
        .pcSrc_M     (pcSrc_M),
        .dmem_busy_M (dmem_busy_M),
        .stall_F     (stall_F),
        .stall_D     (stall_D),
        .flush_D     (flush_D),
        .flush_E     (flush_E),
        .flush_M     (flush_M),
        .freeze      (freeze),
        .state       (state),
        .stall_count (stall_count),
        .flush_count (flush_count),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d @%0t",
                     name, act, exp, $time);
    endtask

    function automatic bit m_lu();
        return memRead_E && regWrite_E && wa3_E != 5'd31 &&
               (wa3_E == ra1_D || wa3_E == ra2_D);
    endfunction

    // Expected {stall_F,stall_D,flush_D,flush_E,flush_M,freeze}.
    function automatic int m_ctl();
        if (dmem_busy_M) return 6'b110001;
        if (pcSrc_M)     return 6'b001110;
        if (m_lu())      return 6'b110100;
        return 0;
    endfunction

    // Reference model advances on each rising edge.
    always @(posedge clk) begin
        int c;
        c = m_ctl();
        if (reset) begin
            m_state = 0; m_sc = 0; m_fc = 0; m_run = 0; m_to = 0;
        end else begin
            m_state = dmem_busy_M ? 3 : pcSrc_M ? 2 : m_lu() ? 1 : 0;
            if (c[4] && !c[0] && m_sc < SMAX) m_sc++;
            if (c[3] && m_fc < SMAX) m_fc++;
            m_run = dmem_busy_M ? ((m_run < MAXF) ? m_run + 1 : MAXF) : 0;
            if (m_run == MAXF) m_to = 1;
        end
        started = 1;
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            chk("ctl", int'({stall_F, stall_D, flush_D,
                             flush_E, flush_M, freeze}), m_ctl());
            chk("state", int'(state), m_state);
            chk("stall_count", int'(stall_count), m_sc);
            chk("flush_count", int'(flush_count), m_fc);
            chk("timeout", int'(timeout), m_to);
        end
    end

    task automatic apply(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] w, input logic mr,
                         input logic rw, input logic pc,
                         input logic busy);
        ra1_D = a1; ra2_D = a2; wa3_E = w;
        memRead_E = mr; regWrite_E = rw;
        pcSrc_M = pc; dmem_busy_M = busy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick(); tick();
        reset = 1'b0;
        chk("rst_state", int'(state), 0);
        chk("rst_stall_count", int'(stall_count), 0);
        chk("rst_timeout", int'(timeout), 0);

        // load-use on ra1
        apply(3, 0, 3, 1, 1, 0, 0);
        chk("lu_stall", int'({stall_F, stall_D, flush_E}), 7);
        chk("lu_flush_d", int'(flush_D), 0);
        tick();
        chk("lu_count", int'(stall_count), 1);
        chk("lu_state", int'(state), 1);
        idle();
        chk("lu_one_cycle", int'(stall_D), 0);
        tick();
        chk("run_state", int'(state), 0);

        // XZR never hazards
        apply(0, 31, 31, 1, 1, 0, 0);
        chk("xzr_stall", int'(stall_D), 0);
        tick();
        chk("xzr_count", int'(stall_count), 1);

        // not a write-back load
        apply(5, 0, 5, 1, 0, 0, 0);
        tick();
        // load-use on ra2
        apply(0, 7, 7, 1, 1, 0, 0);
        tick();
        chk("ra2_count", int'(stall_count), 2);

        // branch beats load-use
        apply(4, 0, 4, 1, 1, 1, 0);
        chk("br_flush", int'({flush_D, flush_E, flush_M}), 7);
        chk("br_stall", int'(stall_D), 0);
        tick();
        chk("br_count", int'(flush_count), 1);
        chk("br_state", int'(state), 2);

        // back-to-back load-use
        for (int i = 0; i < 3; i++) begin
            apply(5'(i + 8), 0, 5'(i + 8), 1, 1, 0, 0);
            tick();
        end
        chk("b2b_count", int'(stall_count), 5);

        // freeze with branch pending
        apply(0, 0, 0, 0, 0, 1, 1);
        chk("frz_out", int'({freeze, stall_F, stall_D}), 7);
        chk("frz_flush", int'({flush_D, flush_E, flush_M}), 0);
        for (int i = 0; i < 15; i++) tick();
        chk("frz15_timeout", int'(timeout), 0);
        tick();
        chk("frz16_timeout", int'(timeout), 1);
        chk("frz_state", int'(state), 3);
        chk("frz_stall_count", int'(stall_count), 5);
        idle();
        tick();
        chk("timeout_sticky", int'(timeout), 1);
        chk("frz_flush_count", int'(flush_count), 1);

        // stall counter saturation
        for (int i = 0; i < 12; i++) begin
            apply(2, 0, 2, 1, 1, 0, 0);
            tick();
        end
        chk("stall_sat", int'(stall_count), 15);

        // flush counter saturation
        for (int i = 0; i < 16; i++) begin
            apply(0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        chk("flush_sat", int'(flush_count), 15);

        // reset in the middle of a freeze
        apply(0, 0, 0, 0, 0, 0, 1);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("rst_unmasked", int'(freeze), 1);
        tick();
        reset = 1'b0;
        chk("rst_frz_state", int'(state), 0);
        chk("rst_frz_counts", int'({stall_count, flush_count}), 0);
        chk("rst_frz_timeout", int'(timeout), 0);

        // interrupted freeze restarts the run
        for (int i = 0; i < 10; i++) tick();
        idle();
        tick();
        apply(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) tick();
        chk("split_timeout", int'(timeout), 0);
        idle();
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
